// File: rtl/result_digit_reader.sv
// ============================================================================
// Module   : result_digit_reader
// Brief    : Converts a captured 32-bit result to BCD (double-dabble) and
//            streams the significant digits MSD-first over valid/ready.
//            Optional macro RESULT_SIGNED_EN: treat data_in as two's complement.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_digit_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic [3:0]  digit,
    output logic        digit_valid,
    input  logic        digit_ready,
    output logic        digit_last,
    output logic        negative
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_ALIGN   = 2'd2,
        S_SEND    = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_STEP = 5'd31;
    localparam int         c_NIBBLES   = 10;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_bin;
    logic [39:0] r_bcd;
    logic [4:0]  r_step;
    logic [3:0]  r_index;
    logic [39:0] w_bcd_adj;
    logic [31:0] w_magnitude;
    logic [3:0]  w_msd_index;
    logic        w_xfer;

`ifdef RESULT_SIGNED_EN
    assign w_magnitude = data_in[31] ? (~data_in + 32'd1) : data_in;

    logic r_negative;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_negative <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_negative <= data_in[31];
        end
    end
    assign negative = r_negative;
`else
    assign w_magnitude = data_in;
    assign negative    = 1'b0;
`endif

    // Add-3 correction applied to every nibble before each shift.
    generate
        for (genvar g = 0; g < c_NIBBLES; g++) begin : g_dabble
            assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                         (r_bcd[4*g +: 4] + 4'd3) : r_bcd[4*g +: 4];
        end
    endgenerate

    // Highest nonzero nibble wins; an all-zero result points at the units digit.
    always_comb begin
        w_msd_index = 4'd0;
        for (int i = 0; i < c_NIBBLES; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_msd_index = 4'(i);
            end
        end
    end

    assign w_xfer = (r_state == S_SEND) && digit_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        digit        = 4'd0;
        digit_valid  = 1'b0;
        digit_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                busy = 1'b1;
                if (r_step == c_LAST_STEP) begin
                    w_state_next = S_ALIGN;
                end
            end
            S_ALIGN: begin
                busy         = 1'b1;
                w_state_next = S_SEND;
            end
            S_SEND: begin
                busy        = 1'b1;
                digit_valid = 1'b1;
                digit       = r_bcd[{r_index, 2'b00} +: 4];
                digit_last  = (r_index == 4'd0);
                if (w_xfer && r_index == 4'd0) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin   <= 32'd0;
            r_bcd   <= 40'd0;
            r_step  <= 5'd0;
            r_index <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin  <= w_magnitude;
                        r_bcd  <= 40'd0;
                        r_step <= 5'd0;
                    end
                end
                S_CONVERT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_step         <= r_step + 5'd1;
                end
                S_ALIGN: begin
                    r_index <= w_msd_index;
                end
                S_SEND: begin
                    if (w_xfer && r_index != 4'd0) begin
                        r_index <= r_index - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_result_digit_reader.sv
// ============================================================================
// Module   : tb_result_digit_reader
// Brief    : Self-checking bench for result_digit_reader; decimal reference
//            model plus directed and randomized conversions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_digit_reader;

    logic        clk         = 1'b0;
    logic        reset       = 1'b0;
    logic        start       = 1'b0;
    logic        digit_ready = 1'b0;
    logic [31:0] data_in     = 32'd0;
    logic        busy;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        digit_last;
    logic        negative;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    int m_phase = 0;   // 0 idle, 1 converting, 2 sending
    int m_cnt   = 0;
    bit m_neg   = 1'b0;
    int m_q[$];

    int cap_q[$];
    int cap_last_pos;
    int cap_span;
    int exp_q[$];
    int lit[$];

    always #5 clk = ~clk;

    result_digit_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit_last  (digit_last),
        .negative    (negative)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint unsigned magnitude(input logic [31:0] v);
`ifdef RESULT_SIGNED_EN
        if (v[31]) return 64'h1_0000_0000 - {32'd0, v};
`endif
        return {32'd0, v};
    endfunction

    function automatic bit sign_of(input logic [31:0] v);
`ifdef RESULT_SIGNED_EN
        return v[31];
`else
        return (v != v);
`endif
    endfunction

    task automatic make_exp(input logic [31:0] v);
        longint unsigned m;
        m = magnitude(v);
        exp_q.delete();
        do begin
            exp_q.push_front(int'(m % 10));
            m = m / 10;
        end while (m != 0);
    endtask

    // Reference model: decimal digit queue and a cycle count since acceptance.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_phase = 0;
            m_neg   = 1'b0;
            m_q.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    longint unsigned m;
                    m = magnitude(data_in);
                    m_neg = sign_of(data_in);
                    m_q.delete();
                    do begin
                        m_q.push_front(int'(m % 10));
                        m = m / 10;
                    end while (m != 0);
                    m_cnt   = 0;
                    m_phase = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == 33) m_phase = 2;
                end
                default: if (digit_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_phase = 0;
                end
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("busy", busy, m_phase != 0);
            check("digit_valid", digit_valid, m_phase == 2);
            check("digit_last", digit_last, (m_phase == 2) && (m_q.size() == 1));
            check("negative", negative, m_neg);
            if (m_phase == 2) check("digit", digit, m_q[0]);
        end
    end

    // rmode: 0 ready always high, 1 toggling, 2 random.
    task automatic run(input logic [31:0] v, input int rmode, input bit disturb, input int abort_at);
        int cyc;
        cap_q.delete();
        cap_last_pos = -1;
        make_exp(v);
        data_in = v;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (1) begin
            case (rmode)
                0:       digit_ready = 1'b1;
                1:       digit_ready = cyc[0];
                default: digit_ready = 1'($urandom_range(0, 1));
            endcase
            if (disturb) begin
                start = (cyc == 10) || (cyc == 36);
                if (cyc == 10) data_in = 32'd7;
            end
            @(negedge clk);
            if (digit_valid && digit_ready) begin
                if (digit_last) cap_last_pos = cap_q.size();
                cap_q.push_back(int'(digit));
            end
            @(posedge clk); #1;
            cyc++;
            if (abort_at > 0 && cap_q.size() == abort_at) break;
            if (!busy) break;
            if (cyc > 400) begin
                check("timeout_busy", 1, 0);
                break;
            end
        end
        start       = 1'b0;
        digit_ready = 1'b0;
        cap_span    = cyc;
    endtask

    task automatic cmp_caps(input string name);
        check({name, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check({name, "_digit"}, cap_q[i], exp_q[i]);
        check({name, "_lastpos"}, cap_last_pos, exp_q.size() - 1);
    endtask

    task automatic cmp_lit(input string name);
        check({name, "_litcount"}, cap_q.size(), lit.size());
        for (int i = 0; i < lit.size() && i < cap_q.size(); i++)
            check({name, "_litdigit"}, cap_q[i], lit[i]);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_digit", digit, 0);
        check("rst_valid", digit_valid, 0);
        check("rst_last", digit_last, 0);
        check("rst_negative", negative, 0);
        @(posedge clk); #1;
        reset  = 1'b0;
        cmp_en = 1'b1;

        run(32'd0, 0, 0, 0);
        lit = {0};
        cmp_lit("zero");
        cmp_caps("zero");
        check("zero_busy_cycles", cap_span + 1, 35);
        check("zero_negative", negative, 0);

        run(32'hFFFF_FFFF, 0, 0, 0);
        cmp_caps("allones");
`ifdef RESULT_SIGNED_EN
        lit = {1};
        cmp_lit("minus_one");
        check("minus_one_negative", negative, 1);
`else
        lit = {4, 2, 9, 4, 9, 6, 7, 2, 9, 5};
        cmp_lit("max");
        check("max_busy_cycles", cap_span + 1, 44);
`endif

        run(32'd1000, 1, 0, 0);
        lit = {1, 0, 0, 0};
        cmp_lit("stall1000");
        cmp_caps("stall1000");

        run(32'd987654321, 0, 1, 0);
        lit = {9, 8, 7, 6, 5, 4, 3, 2, 1};
        cmp_lit("disturb");

        run(32'd12345, 0, 0, 2);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_digit", digit, 0);
        check("midrst_valid", digit_valid, 0);
        check("midrst_last", digit_last, 0);
        check("midrst_negative", negative, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run(32'd9, 0, 0, 0);
        lit = {9};
        cmp_lit("after_reset");
        check("after_reset_lastpos", cap_last_pos, 0);

`ifdef RESULT_SIGNED_EN
        run(32'h8000_0000, 0, 0, 0);
        lit = {2, 1, 4, 7, 4, 8, 3, 6, 4, 8};
        cmp_lit("most_negative");
        check("most_negative_neg", negative, 1);
        run(32'd5, 0, 0, 0);
        lit = {5};
        cmp_lit("five");
        check("five_neg", negative, 0);
`endif

        for (int k = 0; k < 25; k++) begin
            logic [31:0] v;
            int          rm;
            v  = $urandom >> $urandom_range(0, 31);
            rm = (k % 3 == 0) ? 0 : 2;
            run(v, rm, 0, 0);
            cmp_caps("random");
            if (rm == 0) check("random_busy_cycles", cap_span + 1, 34 + exp_q.size());
        end

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
